// File: rtl/p_hit_pkg.sv
// Shared constants and types for the ray/plane hit-point block.
// Fixed-point values are signed 32-bit with Q_BITS fractional bits; products are full 64-bit.
package p_hit_pkg;

    localparam int Q_BITS_DEFAULT    = 16;
    localparam int FX_W              = 32;
    localparam int PROD_W            = 64;
    localparam int RAY_DEPTH_DEFAULT = 16;
    localparam int OUT_DEPTH_DEFAULT = 8;

    typedef logic signed [FX_W-1:0]   fx_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic [2:0][FX_W-1:0]     vec3_t;   // [0]=x, [1]=y, [2]=z

    // Both operands are sign-extended before multiplying so the product is exact.
    function automatic prod_t fx_mul(fx_t a, fx_t b);
        return prod_t'(a) * prod_t'(b);
    endfunction

endpackage

// File: rtl/p_hit_point_if.sv
// Data-side signals of p_hit_point: t source, ray input buffer and output point FIFO.
interface p_hit_point_if;
    import p_hit_pkg::*;

    fx_t   t_in;
    logic  t_empty;
    logic  t_rd_en;
    vec3_t origin;
    vec3_t dir;
    logic  in_wr_en;
    logic  in_full;
    vec3_t point;
    logic  out_empty;
    logic  out_rd_en;

    modport master (
        output t_in, t_empty, origin, dir, in_wr_en, out_rd_en,
        input  t_rd_en, in_full, point, out_empty
    );

    modport slave (
        input  t_in, t_empty, origin, dir, in_wr_en, out_rd_en,
        output t_rd_en, in_full, point, out_empty
    );

endinterface

// File: rtl/fifo_array.sv
// First-word-fall-through FIFO whose entries are ARRAY_SIZE words of WIDTH bits.
// Writes while full and reads while empty are ignored; full comes from a registered count.
module fifo_array #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 3,
    parameter int DEPTH      = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [ARRAY_SIZE-1:0][WIDTH-1:0]    din,
    output logic                                full,
    input  logic                                rd_en,
    output logic [ARRAY_SIZE-1:0][WIDTH-1:0]    dout,
    output logic                                empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ARRAY_SIZE-1:0][WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr, do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            if (do_wr != do_rd) count <= do_wr ? count + CW'(1) : count - CW'(1);
        end
    end

    // NOTE: storage is deliberately left unreset; the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/p_hit_point_lane.sv
// One component of origin + ((t * dir) >>> Q_BITS): operands captured on load,
// 64-bit product on advance, shift-and-add left combinational for the output FIFO write.
module p_hit_point_lane
    import p_hit_pkg::*;
#(
    parameter int Q_BITS = Q_BITS_DEFAULT
) (
    input  logic clock,
    input  logic load,
    input  logic advance,
    input  fx_t  t,
    input  fx_t  origin,
    input  fx_t  dir,
    output fx_t  sum
);

    fx_t   t_q, origin_q, dir_q, origin_q2;
    prod_t prod_q;

    always_ff @(posedge clock) begin
        if (load) begin
            t_q      <= t;
            origin_q <= origin;
            dir_q    <= dir;
        end
        if (advance) begin
            prod_q    <= fx_mul(t_q, dir_q);
            origin_q2 <= origin_q;
        end
    end

    // Arithmetic shift floors toward -inf; the add wraps modulo 2^32.
    assign sum = origin_q2 + fx_t'(prod_q >>> Q_BITS);

endmodule

// File: rtl/p_hit_point.sv
// Pairs buffered rays with upstream t values in arrival order and emits hit points
// through a credit-protected FWFT output FIFO, one point per cycle at full rate.
module p_hit_point
    import p_hit_pkg::*;
#(
    parameter int Q_BITS    = Q_BITS_DEFAULT,
    parameter int RAY_DEPTH = RAY_DEPTH_DEFAULT,
    parameter int OUT_DEPTH = OUT_DEPTH_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    p_hit_point_if.slave  bus
);

    localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCW = $clog2(OUT_DEPTH + 1);

    vec3_t ray_origin, ray_dir, sums;
    logic  org_full, dir_full, org_empty, dir_empty;
    logic  pop, s1_valid, s2_valid, out_rd;

    vec3_t          out_mem [OUT_DEPTH];
    logic [OAW-1:0] out_wr_ptr, out_rd_ptr;
    logic [OCW-1:0] out_count;

    fifo_array #(.WIDTH(FX_W), .ARRAY_SIZE(3), .DEPTH(RAY_DEPTH)) u_origin_fifo (
        .clock (clock),         .reset (reset),
        .wr_en (bus.in_wr_en),  .din   (bus.origin), .full  (org_full),
        .rd_en (pop),           .dout  (ray_origin), .empty (org_empty)
    );

    fifo_array #(.WIDTH(FX_W), .ARRAY_SIZE(3), .DEPTH(RAY_DEPTH)) u_dir_fifo (
        .clock (clock),         .reset (reset),
        .wr_en (bus.in_wr_en),  .din   (bus.dir),    .full  (dir_full),
        .rd_en (pop),           .dout  (ray_dir),    .empty (dir_empty)
    );

    assign bus.in_full = org_full | dir_full;

    // Items already in the pipe hold an output slot, so the FIFO can never overflow.
    assign pop = !bus.t_empty && !org_empty && !dir_empty &&
                 (int'(out_count) + int'(s1_valid) + int'(s2_valid) < OUT_DEPTH);
    assign bus.t_rd_en = pop;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        p_hit_point_lane #(.Q_BITS(Q_BITS)) u_lane (
            .clock   (clock),
            .load    (pop),
            .advance (s1_valid),
            .t       (bus.t_in),
            .origin  (ray_origin[i]),
            .dir     (ray_dir[i]),
            .sum     (sums[i])
        );
    end

    assign out_rd = bus.out_rd_en && (out_count != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            s1_valid <= pop;
            s2_valid <= s1_valid;
            if (s2_valid) out_wr_ptr <= (out_wr_ptr == OAW'(OUT_DEPTH - 1)) ? '0 : out_wr_ptr + OAW'(1);
            if (out_rd)   out_rd_ptr <= (out_rd_ptr == OAW'(OUT_DEPTH - 1)) ? '0 : out_rd_ptr + OAW'(1);
            if (s2_valid != out_rd) out_count <= s2_valid ? out_count + OCW'(1) : out_count - OCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (s2_valid) out_mem[out_wr_ptr] <= sums;
    end

    assign bus.out_empty = (out_count == '0);
    assign bus.point     = bus.out_empty ? '0 : out_mem[out_rd_ptr];

endmodule

// File: tb/tb_p_hit_point.sv
// Self-checking bench for p_hit_point: hand-computed vector table, multi-cycle corner
// sequences and a queue-based reference model fed with $urandom stimulus.
module tb_p_hit_point;
    import p_hit_pkg::*;

    localparam int Q    = 16;
    localparam int RAYS = 16;
    localparam int OUTS = 8;

    typedef struct {
        logic [31:0] t;
        vec3_t       origin;
        vec3_t       dir;
        vec3_t       exp_point;
    } vec_t;

    typedef struct {
        vec3_t origin;
        vec3_t dir;
    } ray_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    p_hit_point_if bus ();

    p_hit_point #(.Q_BITS(Q), .RAY_DEPTH(RAYS), .OUT_DEPTH(OUTS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int reads  = 0;
    logic last_pop = 1'b0;

    logic [31:0] t_src [$];   // upstream t values, head is on t_in
    ray_t        ray_m [$];   // rays accepted into the buffer
    vec3_t       exp_q [$];   // points owed to the output, oldest first

    task automatic check(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec3_t v3(logic [31:0] x, logic [31:0] y, logic [31:0] z);
        return {z, y, x};
    endfunction

    function automatic vec3_t rand_vec();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // point = origin + floor(t * dir / 2^Q), wrapped to 32 bits
    function automatic vec3_t ref_point(logic [31:0] t, vec3_t origin, vec3_t dir);
        vec3_t r;
        for (int i = 0; i < 3; i++) begin
            longint prod   = longint'($signed(t)) * longint'($signed(dir[i]));
            longint scaled = prod >>> Q;
            r[i] = 32'(longint'($signed(origin[i])) + scaled);
        end
        return r;
    endfunction

    task automatic drive_t();
        if (t_src.size() == 0) begin
            bus.t_empty = 1'b1;
            bus.t_in    = '0;
        end else begin
            bus.t_empty = 1'b0;
            bus.t_in    = t_src[0];
        end
    endtask

    task automatic push_t(logic [31:0] t);
        t_src.push_back(t);
        drive_t();
    endtask

    // One clock: sample at the falling edge, update the model just after the rising edge.
    task automatic tick();
        logic  pop_s, wr_s, rd_s, full_s;
        ray_t  wr_ray, pr;
        vec3_t pt;
        @(negedge clock);
        pop_s         = bus.t_rd_en;
        wr_s          = bus.in_wr_en;
        rd_s          = bus.out_rd_en && !bus.out_empty;
        wr_ray.origin = bus.origin;
        wr_ray.dir    = bus.dir;
        pt            = bus.point;
        full_s        = (ray_m.size() >= RAYS);
        @(posedge clock);
        #1;
        last_pop = pop_s;
        if (rd_s) begin
            check("sb_output_expected", 96'(exp_q.size() != 0), 96'(1));
            if (exp_q.size() != 0) check("sb_point", pt, exp_q.pop_front());
            reads++;
        end
        if (pop_s) begin
            check("pop_has_data", 96'(ray_m.size() != 0 && t_src.size() != 0), 96'(1));
            if (ray_m.size() != 0 && t_src.size() != 0) begin
                pr = ray_m.pop_front();
                exp_q.push_back(ref_point(t_src.pop_front(), pr.origin, pr.dir));
            end
            pops++;
        end
        if (wr_s && !full_s) ray_m.push_back(wr_ray);
        drive_t();
    endtask

    task automatic write_ray(vec3_t origin, vec3_t dir);
        bus.origin   = origin;
        bus.dir      = dir;
        bus.in_wr_en = 1'b1;
        tick();
        bus.in_wr_en = 1'b0;
    endtask

    task automatic wait_pop(string name, int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_pop && n < budget);
        check(name, 96'(last_pop), 96'(1));
    endtask

    task automatic drain(int budget);
        int n = 0;
        bus.out_rd_en = 1'b1;
        while ((exp_q.size() != 0 || (ray_m.size() != 0 && t_src.size() != 0)) && n < budget) begin
            tick();
            n++;
        end
        bus.out_rd_en = 1'b0;
        check("drain_complete", 96'(exp_q.size()), 96'(0));
        check("drain_out_empty", 96'(bus.out_empty), 96'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [5];
        int   pb, rb, n;

        tbl[0] = '{t: 32'h0002_0000,
                   origin: v3(32'h0, 32'h0001_0000, 32'h0003_0000),
                   dir: v3(32'h0001_0000, 32'h0, 32'hFFFF_8000),
                   exp_point: v3(32'h0002_0000, 32'h0001_0000, 32'h0002_0000)};
        tbl[1] = '{t: 32'hFFFF_8000,
                   origin: v3(32'h0, 32'h0, 32'h0),
                   dir: v3(32'h0000_0001, 32'h0, 32'h0),
                   exp_point: v3(32'hFFFF_FFFF, 32'h0, 32'h0)};
        tbl[2] = '{t: 32'h0001_0000,
                   origin: v3(32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF),
                   dir: v3(32'h7FFF_FFFF, 32'h0, 32'h8000_0000),
                   exp_point: v3(32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF)};
        tbl[3] = '{t: 32'h7FFF_FFFF,
                   origin: v3(32'h0, 32'h0, 32'h0),
                   dir: v3(32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000),
                   exp_point: v3(32'hFFFF_0000, 32'h0000_8000, 32'h7FFF_FFFF)};
        tbl[4] = '{t: 32'hFFFF_0000,
                   origin: v3(32'h0005_0000, 32'h0, 32'h0000_0007),
                   dir: v3(32'h0003_0000, 32'hFFFF_FFFF, 32'h0),
                   exp_point: v3(32'h0002_0000, 32'h0000_0001, 32'h0000_0007)};

        bus.t_in      = '0;
        bus.t_empty   = 1'b1;
        bus.origin    = '0;
        bus.dir       = '0;
        bus.in_wr_en  = 1'b0;
        bus.out_rd_en = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_t_rd_en", 96'(bus.t_rd_en), 96'(0));
        check("rst_in_full", 96'(bus.in_full), 96'(0));
        check("rst_out_empty", 96'(bus.out_empty), 96'(1));
        check("rst_point", bus.point, 96'(0));

        // Release with a ray and t already waiting: no pop on the first edge, pop on the second
        reset        = 1'b1;
        bus.origin   = rand_vec();
        bus.dir      = rand_vec();
        bus.in_wr_en = 1'b1;
        push_t($urandom());
        tick();
        bus.in_wr_en = 1'b0;
        check("first_edge_no_pop", 96'(last_pop), 96'(0));
        tick();
        check("second_edge_pop", 96'(last_pop), 96'(1));
        drain(20);

        // Table vectors, with exact output latency
        for (int i = 0; i < 5; i++) begin
            write_ray(tbl[i].origin, tbl[i].dir);
            push_t(tbl[i].t);
            wait_pop($sformatf("vec%0d_pop", i), 10);
            check($sformatf("vec%0d_empty_n", i), 96'(bus.out_empty), 96'(1));
            tick();
            check($sformatf("vec%0d_empty_n1", i), 96'(bus.out_empty), 96'(1));
            tick();
            check($sformatf("vec%0d_empty_n2", i), 96'(bus.out_empty), 96'(0));
            check($sformatf("vec%0d_point", i), bus.point, tbl[i].exp_point);
            bus.out_rd_en = 1'b1;
            tick();
            bus.out_rd_en = 1'b0;
        end

        // Backpressure: 10 rays and 10 t with no reads -> only 8 accepted
        pb = pops;
        rb = reads;
        for (int i = 0; i < 10; i++) t_src.push_back($urandom());
        drive_t();
        for (int i = 0; i < 10; i++) write_ray(rand_vec(), rand_vec());
        repeat (12) tick();
        check("bp_pops", 96'(pops - pb), 96'(8));
        check("bp_t_rd_en_low", 96'(bus.t_rd_en), 96'(0));
        check("bp_out_nonempty", 96'(bus.out_empty), 96'(0));
        drain(100);
        check("bp_reads", 96'(reads - rb), 96'(10));

        // Full ray buffer: the 17th write is dropped
        for (int i = 1; i <= 17; i++) begin
            write_ray(rand_vec(), rand_vec());
            if (i == 15) check("full_low_at_15", 96'(bus.in_full), 96'(0));
            if (i == 16) check("full_high_at_16", 96'(bus.in_full), 96'(1));
        end
        rb = reads;
        for (int i = 0; i < 16; i++) t_src.push_back($urandom());
        drive_t();
        drain(200);
        check("full_reads", 96'(reads - rb), 96'(16));
        pb = pops;
        push_t($urandom());
        repeat (6) tick();
        check("full_17th_dropped", 96'(pops - pb), 96'(0));
        t_src.delete();
        drive_t();

        // Reset while two items are in flight
        for (int i = 0; i < 4; i++) write_ray(rand_vec(), rand_vec());
        for (int i = 0; i < 4; i++) t_src.push_back($urandom());
        drive_t();
        tick();
        tick();
        check("midrst_two_popped", 96'(last_pop), 96'(1));
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out_empty", 96'(bus.out_empty), 96'(1));
        check("midrst_t_rd_en", 96'(bus.t_rd_en), 96'(0));
        t_src.delete();
        ray_m.delete();
        exp_q.delete();
        drive_t();
        tick();
        tick();
        reset = 1'b1;
        pb = pops;
        n  = 0;
        repeat (10) begin
            tick();
            if (!bus.out_empty) n++;
        end
        check("midrst_no_stale", 96'(n), 96'(0));
        check("midrst_no_pops", 96'(pops - pb), 96'(0));

        // Ordering: 5 rays, t values arriving after random 0-3 cycle gaps
        rb = reads;
        for (int i = 0; i < 5; i++) write_ray(rand_vec(), rand_vec());
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(3)) tick();
            push_t($urandom());
        end
        drain(100);
        check("order_reads", 96'(reads - rb), 96'(5));

        // Random traffic on all three sides
        for (int c = 0; c < 300; c++) begin
            bus.origin    = rand_vec();
            bus.dir       = rand_vec();
            bus.in_wr_en  = ($urandom_range(1) == 1);
            bus.out_rd_en = ($urandom_range(2) != 0);
            if ($urandom_range(1) == 1) push_t($urandom());
            tick();
        end
        bus.in_wr_en = 1'b0;
        while (t_src.size() < ray_m.size()) t_src.push_back($urandom());
        drive_t();
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
